// File: rtl/mac_pkg.sv
// Shared types for the sequential Booth MAC: FSM state encoding, Booth step
// decode and the iteration counter width.
package mac_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ACC  = 2'd2,
        S_OUT  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_e;

    // $clog2(n) bits are enough to count steps 0..n-1; keep at least one bit.
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic booth_op_e booth_decode(input logic q0, input logic q_m1);
        booth_op_e op;
        case ({q0, q_m1})
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/add_sub_nbit.sv
// Exact W-bit signed adder/subtractor: s = a + b (k=0) or a - b (k=1),
// returned one bit wider so the result never wraps.
module Add_Sub_Nbit #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         k,
    output logic [W:0]   s
);

    assign s = {a[W-1], a} + ({b[W-1], b} ^ {(W+1){k}}) + (W+1)'(k);

endmodule

// File: rtl/seq_booth_mult.sv
// Radix-2 Booth multiplier, one step per cycle. start loads the operands;
// done is high during the final step, product is valid the cycle after.
module seq_booth_mult
    import mac_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CNT_W = cnt_w(N);

    logic [N:0]       hi;
    logic [N-1:0]     q;
    logic             q_m1;
    logic [N-1:0]     m;
    logic [CNT_W-1:0] cnt;
    logic             busy;

    booth_op_e        op;
    logic [N:0]       addend;
    logic             k;
    logic [N+1:0]     sum;

    assign op     = booth_decode(q[0], q_m1);
    assign addend = (op == OP_NOP) ? '0 : {m[N-1], m};
    assign k      = (op == OP_SUB);

    // One bit of headroom beyond N+1 keeps M = -2^(N-1) exact through the subtract.
    Add_Sub_Nbit #(.W(N+1)) u_add (
        .a (hi),
        .b (addend),
        .k (k),
        .s (sum)
    );

    assign done    = busy && (cnt == CNT_W'(N-1));
    assign product = {hi[N-1:0], q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi   <= '0;
            q    <= '0;
            q_m1 <= 1'b0;
            m    <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            hi   <= '0;
            q    <= b;
            q_m1 <= 1'b0;
            m    <= a;
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            hi   <= sum[N+1:1];
            q    <= {sum[0], q[N-1:1]};
            q_m1 <= q[0];
            cnt  <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/booth_mac_seq.sv
// Sequential signed multiply-accumulate: one Booth product per operand pair,
// summed into a wrapping accumulator and presented downstream on the last pair.
module booth_mac_seq
    import mac_pkg::*;
#(
    parameter int N     = 4,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] y,
    output logic             ovf
);

    state_e           state;
    state_e           state_n;
    logic             start;
    logic             mul_done;
    logic [2*N-1:0]   product;
    logic [ACC_W-1:0] p_ext;
    logic [ACC_W:0]   acc_sum;
    logic             this_ovf;

    logic [ACC_W-1:0] acc;
    logic             ovf_acc;
    logic             last_r;
    logic [ACC_W-1:0] y_r;
    logic             ovf_r;

    seq_booth_mult #(.N(N)) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (product)
    );

    assign p_ext = ACC_W'($signed(product));

    Add_Sub_Nbit #(.W(ACC_W)) u_acc_add (
        .a (acc),
        .b (p_ext),
        .k (1'b0),
        .s (acc_sum)
    );

    assign this_ovf = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];

    always_comb begin
        state_n   = state;
        start     = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    start   = 1'b1;
                    state_n = S_MUL;
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    state_n = S_ACC;
                end
            end
            S_ACC: begin
                state_n = last_r ? S_OUT : S_IDLE;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            acc     <= '0;
            ovf_acc <= 1'b0;
            last_r  <= 1'b0;
            y_r     <= '0;
            ovf_r   <= 1'b0;
        end else begin
            state <= state_n;
            if (start) begin
                last_r <= in_last;
            end
            // The last element publishes the sum and leaves a clean accumulator.
            if (state == S_ACC) begin
                if (last_r) begin
                    y_r     <= acc_sum[ACC_W-1:0];
                    ovf_r   <= ovf_acc | this_ovf;
                    acc     <= '0;
                    ovf_acc <= 1'b0;
                end else begin
                    acc     <= acc_sum[ACC_W-1:0];
                    ovf_acc <= ovf_acc | this_ovf;
                end
            end
        end
    end

    assign y   = y_r;
    assign ovf = ovf_r;

endmodule

// File: tb/tb_booth_mac_seq.sv
// Directed and scoreboard checks for booth_mac_seq at N=4, ACC_W=12.
module tb_booth_mac_seq;

    localparam int N     = 4;
    localparam int ACC_W = 12;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [N-1:0]     a;
    logic signed [N-1:0]     b;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] y;
    logic                    ovf;

    int n_total = 0;
    int n_pass  = 0;

    booth_mac_seq #(.N(N), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [N-1:0]     a;
        logic signed [N-1:0]     b;
        logic                    last;
        logic signed [ACC_W-1:0] y;
        logic                    ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic send(input logic signed [N-1:0] ta, input logic signed [N-1:0] tb,
                        input logic tl);
        int w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
        end
        a        = ta;
        b        = tb;
        in_last  = tl;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called right after send() of a last element; lat counts the accept cycle as 1.
    task automatic get_out(input string name, input logic signed [ACC_W-1:0] ey,
                           input logic eovf, input int stall, output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            check({name, "_out_valid_timeout"}, 32'(out_valid), 32'd1);
        end else begin
            check({name, "_y"}, 32'(y), 32'(ey));
            check({name, "_ovf"}, 32'(ovf), 32'(eovf));
            for (int i = 0; i < stall; i++) begin
                a        = 4'sd7;
                b        = 4'sd7;
                in_last  = 1'b1;
                in_valid = 1'b1;
                @(negedge clk);
                check({name, "_stall_valid"}, 32'(out_valid), 32'd1);
                check({name, "_stall_y"}, 32'(y), 32'(ey));
                check({name, "_stall_in_ready"}, 32'(in_ready), 32'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            check({name, "_released"}, 32'(out_valid), 32'd0);
            check({name, "_idle_ready"}, 32'(in_ready), 32'd1);
        end
    endtask

    task automatic mac_last(input string name, input logic signed [N-1:0] ta,
                            input logic signed [N-1:0] tb, input logic signed [ACC_W-1:0] ey,
                            input logic eovf, input int stall);
        int lat;
        out_ready = (stall == 0);
        send(ta, tb, 1'b1);
        get_out(name, ey, eovf, stall, lat);
    endtask

    vec_t vecs[10];

    initial begin
        int lat;
        logic signed [ACC_W-1:0] acc_m;
        logic                    ovf_m;
        int                      s;
        logic [7:0]              ab;
        logic                    l;

        vecs[0] = '{a: 4'sd3,  b: 4'sd5,  last: 1'b1, y: 12'sd15,  ovf: 1'b0};
        vecs[1] = '{a: -4'sd8, b: -4'sd8, last: 1'b1, y: 12'sd64,  ovf: 1'b0};
        vecs[2] = '{a: -4'sd8, b: 4'sd7,  last: 1'b1, y: -12'sd56, ovf: 1'b0};
        vecs[3] = '{a: 4'sd3,  b: -4'sd2, last: 1'b0, y: 12'sd0,   ovf: 1'b0};
        vecs[4] = '{a: -4'sd7, b: 4'sd5,  last: 1'b0, y: 12'sd0,   ovf: 1'b0};
        vecs[5] = '{a: 4'sd7,  b: 4'sd7,  last: 1'b1, y: 12'sd8,   ovf: 1'b0};
        vecs[6] = '{a: -4'sd1, b: -4'sd1, last: 1'b1, y: 12'sd1,   ovf: 1'b0};
        vecs[7] = '{a: 4'sd7,  b: -4'sd8, last: 1'b1, y: -12'sd56, ovf: 1'b0};
        vecs[8] = '{a: 4'sd0,  b: -4'sd8, last: 1'b1, y: 12'sd0,   ovf: 1'b0};
        vecs[9] = '{a: -4'sd5, b: 4'sd3,  last: 1'b1, y: -12'sd15, ovf: 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_y", 32'(y), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency: accept cycle, N MUL cycles, one ACC cycle, then OUT.
        send(4'sd3, 4'sd5, 1'b1);
        get_out("latency", 12'sd15, 1'b0, 0, lat);
        check("latency_cycles", 32'(lat), 32'(N + 2));

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].last) begin
                mac_last($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].ovf, 0);
            end else begin
                send(vecs[i].a, vecs[i].b, 1'b0);
            end
        end

        mac_last("stall3", -4'sd3, 4'sd6, -12'sd18, 1'b0, 3);
        mac_last("after_stall", 4'sd2, 4'sd3, 12'sd6, 1'b0, 0);

        send(4'sd3, 4'sd3, 1'b0);
        send(4'sd5, 4'sd5, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_y", 32'(y), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        mac_last("post_rst", 4'sd2, 4'sd2, 12'sd4, 1'b0, 0);

        for (int i = 0; i < 31; i++) begin
            send(-4'sd8, -4'sd8, 1'b0);
        end
        mac_last("wrap32", -4'sd8, -4'sd8, -12'sd2048, 1'b1, 0);
        mac_last("ovf_cleared", 4'sd1, 4'sd1, 12'sd1, 1'b0, 0);

        acc_m = '0;
        ovf_m = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ab = 8'(i);
            l  = ($urandom_range(0, 3) == 0) || (i == 255);
            s  = int'(acc_m) + int'($signed(ab[7:4])) * int'($signed(ab[3:0]));
            if (s > 2047 || s < -2048) begin
                ovf_m = 1'b1;
            end
            acc_m = s[ACC_W-1:0];
            if (l) begin
                mac_last($sformatf("rnd%0d", i), $signed(ab[7:4]), $signed(ab[3:0]),
                         acc_m, ovf_m, int'($urandom_range(0, 3)));
                acc_m = '0;
                ovf_m = 1'b0;
            end else begin
                send($signed(ab[7:4]), $signed(ab[3:0]), 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
